// File: rtl/joy_event_queue_if.sv
// Joystick event queue bus: snapshot inputs, CPU pop/clear strobes, FIFO status.
// Latency: n/a (wiring only).
// Backpressure: none; the queue absorbs events and flags overflow instead.
interface joy_event_queue_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic        en;
  logic [11:0] status1;
  logic [11:0] status2;
  logic        rd;
  logic        ovf_clr;
  logic [7:0]  dout;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        ovf;
  logic        busy;

  // Master: poller/CPU side driving snapshots and strobes.
  modport master (
    output en, status1, status2, rd, ovf_clr,
    input  dout, empty, full, count, ovf, busy
  );

  // Slave: the event queue itself.
  modport slave (
    input  en, status1, status2, rd, ovf_clr,
    output dout, empty, full, count, ovf, busy
  );
endinterface

// File: rtl/joy_event_queue.sv
// Turns joystick button changes into press/release bytes queued in a show-ahead FIFO.
// Latency: change seen in IDLE -> 24-cycle scan, one bit per cycle; pushed event on dout/count next cycle.
// Backpressure: none toward the poller; pushes into a full FIFO without a same-cycle pop are dropped and set ovf.
module joy_event_queue #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  joy_event_queue_if.slave bus
);

  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Scanner state
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [23:0] diff_q, diff_d;
  logic [23:0] cur_q, cur_d;
  logic [11:0] snap1_q, snap1_d;
  logic [11:0] snap2_q, snap2_d;

  // Scanner -> FIFO
  logic        push;
  logic [7:0]  push_dat;
  logic        is_j2;
  logic [3:0]  bit_idx;

  // FIFO state
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] remain;
  logic [7:0]  dout_q, dout_d;
  logic        ovf_q, ovf_d;
  logic        full_w;
  logic        do_pop;
  logic        do_push;
  logic        drop;

  // Bits 0..11 belong to joystick 1, 12..23 to joystick 2.
  assign is_j2   = (idx_q >= 5'd12);
  assign bit_idx = is_j2 ? 4'(idx_q - 5'd12) : idx_q[3:0];

  // Scanner next-state: latch the change mask in IDLE, then walk it one bit per cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    diff_d   = diff_q;
    cur_d    = cur_q;
    snap1_d  = snap1_q;
    snap2_d  = snap2_q;
    push     = 1'b0;
    push_dat = 8'h00;
    case (state_q)
      IDLE: begin
        if ((bus.status1 != snap1_q) || (bus.status2 != snap2_q)) begin
          // Snapshot always follows the inputs; events only when enabled.
          snap1_d = bus.status1;
          snap2_d = bus.status2;
          if (bus.en) begin
            diff_d  = {bus.status2 ^ snap2_q, bus.status1 ^ snap1_q};
            cur_d   = {bus.status2, bus.status1};
            idx_d   = 5'd0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        push     = diff_q[idx_q];
        push_dat = {cur_q[idx_q], is_j2, 2'b00, bit_idx};
        if (idx_q == 5'd23) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scanner registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      diff_q  <= 24'd0;
      cur_q   <= 24'd0;
      snap1_q <= 12'd0;
      snap2_q <= 12'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      cur_q   <= cur_d;
      snap1_q <= snap1_d;
      snap2_q <= snap2_d;
    end
  end

  // A pop on a full FIFO frees the slot, so a same-cycle push is never dropped.
  assign full_w  = (cnt_q == CW'(DEPTH));
  assign do_pop  = bus.rd && (cnt_q != '0);
  assign do_push = push && (!full_w || do_pop);
  assign drop    = push && full_w && !do_pop;
  assign remain  = cnt_q - CW'(do_pop);

  // FIFO next-state, including the registered show-ahead head.
  always_comb begin
    rptr_d = rptr_q + AW'(do_pop);
    wptr_d = wptr_q + AW'(do_push);
    cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    ovf_d  = ovf_q;
    dout_d = dout_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    // Head comes from storage unless the FIFO would otherwise be empty,
    // in which case the entry being written this cycle is the new head.
    if (remain != '0) begin
      dout_d = mem[rptr_d];
    end else if (do_push) begin
      dout_d = push_dat;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= push_dat;
    end
  end

  // FIFO pointers, count, head and overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.empty = (cnt_q == '0);
  assign bus.full  = full_w;
  assign bus.count = cnt_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q == SCAN);

endmodule

// File: tb/tb_joy_event_queue.sv
// Self-checking bench for joy_event_queue against a queue-based event model.
// Latency: n/a.
// Backpressure: n/a.
module tb_joy_event_queue;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  joy_event_queue_if #(.DEPTH(DEPTH)) bus ();
  joy_event_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: queued events, sticky overflow, last tracked snapshots.
  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [11:0] m_snap1, m_snap2;

  function automatic void model_push(input logic [7:0] ev);
    if (mq.size() < DEPTH) mq.push_back(ev);
    else m_ovf = 1'b1;
  endfunction

  // Each changed button of J1 then J2, lowest bit first, becomes one event.
  function automatic void model_status(input logic [11:0] s1, input logic [11:0] s2, input bit en_v);
    if (s1 != m_snap1 || s2 != m_snap2) begin
      if (en_v) begin
        for (int j = 0; j < 2; j++) begin
          for (int b = 0; b < 12; b++) begin
            logic [11:0] o, n;
            o = j ? m_snap2 : m_snap1;
            n = j ? s2 : s1;
            if (o[b] != n[b]) model_push({n[b], 1'(j), 2'b00, 4'(b)});
          end
        end
      end
      m_snap1 = s1;
      m_snap2 = s2;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply new snapshots and wait (bounded) for any scan to finish.
  task automatic set_status(input logic [11:0] s1, input logic [11:0] s2, output int busy_cycles);
    bus.status1 = s1;
    bus.status2 = s2;
    model_status(s1, s2, bus.en);
    tick();
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 200) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b1; bus.status1 = '0; bus.status2 = '0; bus.rd = 1'b0; bus.ovf_clr = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_snap1 = '0; m_snap2 = '0;
    repeat (3) tick();
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.ovf !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ovf_busy got=%b%b exp=00", bus.ovf, bus.busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int bc;
    set_status(12'h001, 12'h000, bc);
    checks++; if (bc !== 24) begin errors++; $display("FAIL single_busy got=%0d exp=24", bc); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.count); end
    checks++; if (bus.dout !== 8'h80) begin errors++; $display("FAIL single_press got=%h exp=80", bus.dout); end
    void'(mq.pop_front());
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", bus.empty); end
    // Release: pop strobe lands on the empty FIFO in the very cycle the event is pushed.
    bus.status1 = 12'h000;
    m_snap1 = 12'h000;
    tick();
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    mq.push_back(8'h00);
    checks++; if (bus.count !== 5'd1 || bus.dout !== 8'h00) begin errors++; $display("FAIL empty_push_rd got=%0d/%h exp=1/00", bus.count, bus.dout); end
    repeat (30) tick();
    void'(mq.pop_front());
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    checks++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_end got=%b%b exp=10", bus.empty, bus.busy); end
  endtask

  task automatic test_multi();
    int bc;
    logic [7:0] exp_l [3];
    exp_l = '{8'h86, 8'h87, 8'hCB};
    set_status(12'h0C0, 12'h800, bc);
    checks++; if (bc !== 24) begin errors++; $display("FAIL multi_busy got=%0d exp=24", bc); end
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL multi_count got=%0d exp=3", bus.count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.dout !== exp_l[i]) begin errors++; $display("FAIL multi_ev%0d got=%h exp=%h", i, bus.dout, exp_l[i]); end
      bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    end
    mq.delete();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL multi_empty got=%b exp=1", bus.empty); end
    set_status(12'h000, 12'h000, bc);
    while (mq.size() > 0) begin
      logic [7:0] e8;
      e8 = mq.pop_front();
      checks++; if (bus.dout !== e8) begin errors++; $display("FAIL multi_release got=%h exp=%h", bus.dout, e8); end
      bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    end
  endtask

  task automatic test_disabled();
    int bc;
    bus.en = 1'b0;
    set_status(12'hFFF, 12'h000, bc);
    repeat (3) tick();
    checks++; if (bc !== 0 || bus.count !== '0) begin errors++; $display("FAIL dis_no_events got=%0d/%0d exp=0/0", bc, bus.count); end
    bus.en = 1'b1;
    repeat (30) tick();
    checks++; if (bus.count !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dis_tracked got=%0d/%b exp=0/0", bus.count, bus.busy); end
    bus.en = 1'b0;
    set_status(12'h000, 12'h000, bc);
    bus.en = 1'b1;
  endtask

  task automatic test_overflow();
    int bc;
    set_status(12'hFFF, 12'h000, bc);
    set_status(12'h000, 12'h000, bc);
    set_status(12'hFFF, 12'h000, bc);
    set_status(12'h000, 12'h000, bc);
    checks++; if (bus.count !== 5'(mq.size()) || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%0d/%b exp=%0d/1", bus.count, bus.full, mq.size()); end
    checks++; if (bus.ovf !== m_ovf) begin errors++; $display("FAIL ovf_set got=%b exp=%b", bus.ovf, m_ovf); end
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    m_ovf = 1'b0;
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", bus.ovf); end
    checks++; if (bus.count !== 5'd16 || bus.dout !== mq[0]) begin errors++; $display("FAIL ovf_intact got=%0d/%h exp=16/%h", bus.count, bus.dout, mq[0]); end
  endtask

  task automatic test_full_rd_push();
    int bc;
    logic [7:0] e8;
    // Press J1 bit 2; its push happens in the third scan cycle.
    bus.status1 = m_snap1 | 12'h004;
    m_snap1 = bus.status1;
    repeat (3) tick();
    e8 = mq.pop_front();
    checks++; if (bus.dout !== e8) begin errors++; $display("FAIL fullrp_head got=%h exp=%h", bus.dout, e8); end
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    model_push(8'h82);
    checks++; if (bus.count !== 5'd16 || bus.ovf !== 1'b0) begin errors++; $display("FAIL fullrp_count got=%0d/%b exp=16/0", bus.count, bus.ovf); end
    bc = 0;
    while (bus.busy && bc < 100) begin bc++; tick(); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fullrp_scan_end got=%b exp=0", bus.busy); end
    while (mq.size() > 0) begin
      e8 = mq.pop_front();
      checks++; if (bus.dout !== e8) begin errors++; $display("FAIL fullrp_drain got=%h exp=%h", bus.dout, e8); end
      bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fullrp_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_random();
    int bc, k, exp_bc;
    logic [11:0] s1, s2;
    logic [7:0] e8;
    for (int r = 0; r < 25; r++) begin
      s1 = m_snap1 ^ 12'($urandom & $urandom & $urandom);
      s2 = m_snap2 ^ 12'($urandom & $urandom & $urandom);
      exp_bc = (s1 != m_snap1 || s2 != m_snap2) ? 24 : 0;
      set_status(s1, s2, bc);
      checks++; if (bc !== exp_bc) begin errors++; $display("FAIL rnd_busy r=%0d got=%0d exp=%0d", r, bc, exp_bc); end
      checks++; if (bus.count !== 5'(mq.size()) || bus.ovf !== m_ovf) begin errors++; $display("FAIL rnd_state r=%0d got=%0d/%b exp=%0d/%b", r, bus.count, bus.ovf, mq.size(), m_ovf); end
      k = $urandom_range(0, mq.size());
      for (int i = 0; i < k; i++) begin
        e8 = mq.pop_front();
        checks++; if (bus.dout !== e8) begin errors++; $display("FAIL rnd_pop r=%0d got=%h exp=%h", r, bus.dout, e8); end
        bus.rd = 1'b1; tick(); bus.rd = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
        m_ovf = 1'b0;
      end
    end
    while (mq.size() > 0) begin
      e8 = mq.pop_front();
      checks++; if (bus.dout !== e8) begin errors++; $display("FAIL rnd_drain got=%h exp=%h", bus.dout, e8); end
      bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    end
  endtask

  task automatic test_reset_midscan();
    bus.status1 = m_snap1 ^ 12'h01F;
    bus.status2 = m_snap2;
    repeat (8) tick();
    checks++; if (bus.count !== 5'd5 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%b exp=5/1", bus.count, bus.busy); end
    reset = 1'b1;
    bus.status1 = 12'h000;
    bus.status2 = 12'h000;
    tick();
    checks++; if (bus.empty !== 1'b1 || bus.count !== '0) begin errors++; $display("FAIL mid_clear got=%b/%0d exp=1/0", bus.empty, bus.count); end
    checks++; if (bus.busy !== 1'b0 || bus.dout !== 8'h00 || bus.ovf !== 1'b0) begin errors++; $display("FAIL mid_idle got=%b/%h/%b exp=0/00/0", bus.busy, bus.dout, bus.ovf); end
    reset = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_snap1 = '0; m_snap2 = '0;
    tick();
    bus.rd = 1'b1; tick(); bus.rd = 1'b0;
    tick();
    checks++; if (bus.empty !== 1'b1 || bus.count !== '0 || bus.dout !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_on_empty got=%b/%0d/%h/%b exp=1/0/00/0", bus.empty, bus.count, bus.dout, bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_disabled();
    test_overflow();
    test_full_rd_push();
    test_random();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
